// File: rtl/md5_core.sv
// Fully pipelined MD5 compression core: one 512-bit chunk accepted per enabled cycle,
// 64 register stages each performing one round, final chaining addition off the last stage.
module md5_core (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [511:0] wb_i,
  input  logic [127:0] init_val_i,
  output logic         valid_o,
  output logic [127:0] footprint_o
);

  function automatic logic [31:0] roundK(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'hd76aa478;
      6'd1:  k = 32'he8c7b756;
      6'd2:  k = 32'h242070db;
      6'd3:  k = 32'hc1bdceee;
      6'd4:  k = 32'hf57c0faf;
      6'd5:  k = 32'h4787c62a;
      6'd6:  k = 32'ha8304613;
      6'd7:  k = 32'hfd469501;
      6'd8:  k = 32'h698098d8;
      6'd9:  k = 32'h8b44f7af;
      6'd10: k = 32'hffff5bb1;
      6'd11: k = 32'h895cd7be;
      6'd12: k = 32'h6b901122;
      6'd13: k = 32'hfd987193;
      6'd14: k = 32'ha679438e;
      6'd15: k = 32'h49b40821;
      6'd16: k = 32'hf61e2562;
      6'd17: k = 32'hc040b340;
      6'd18: k = 32'h265e5a51;
      6'd19: k = 32'he9b6c7aa;
      6'd20: k = 32'hd62f105d;
      6'd21: k = 32'h02441453;
      6'd22: k = 32'hd8a1e681;
      6'd23: k = 32'he7d3fbc8;
      6'd24: k = 32'h21e1cde6;
      6'd25: k = 32'hc33707d6;
      6'd26: k = 32'hf4d50d87;
      6'd27: k = 32'h455a14ed;
      6'd28: k = 32'ha9e3e905;
      6'd29: k = 32'hfcefa3f8;
      6'd30: k = 32'h676f02d9;
      6'd31: k = 32'h8d2a4c8a;
      6'd32: k = 32'hfffa3942;
      6'd33: k = 32'h8771f681;
      6'd34: k = 32'h6d9d6122;
      6'd35: k = 32'hfde5380c;
      6'd36: k = 32'ha4beea44;
      6'd37: k = 32'h4bdecfa9;
      6'd38: k = 32'hf6bb4b60;
      6'd39: k = 32'hbebfbc70;
      6'd40: k = 32'h289b7ec6;
      6'd41: k = 32'heaa127fa;
      6'd42: k = 32'hd4ef3085;
      6'd43: k = 32'h04881d05;
      6'd44: k = 32'hd9d4d039;
      6'd45: k = 32'he6db99e5;
      6'd46: k = 32'h1fa27cf8;
      6'd47: k = 32'hc4ac5665;
      6'd48: k = 32'hf4292244;
      6'd49: k = 32'h432aff97;
      6'd50: k = 32'hab9423a7;
      6'd51: k = 32'hfc93a039;
      6'd52: k = 32'h655b59c3;
      6'd53: k = 32'h8f0ccc92;
      6'd54: k = 32'hffeff47d;
      6'd55: k = 32'h85845dd1;
      6'd56: k = 32'h6fa87e4f;
      6'd57: k = 32'hfe2ce6e0;
      6'd58: k = 32'ha3014314;
      6'd59: k = 32'h4e0811a1;
      6'd60: k = 32'hf7537e82;
      6'd61: k = 32'hbd3af235;
      6'd62: k = 32'h2ad7d2bb;
      6'd63: k = 32'heb86d391;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Shift amount depends only on the round group and the position within each group of four.
  function automatic logic [4:0] roundShift(input logic [5:0] idx);
    logic [4:0] s;
    case ({idx[5:4], idx[1:0]})
      4'b0000: s = 5'd7;
      4'b0001: s = 5'd12;
      4'b0010: s = 5'd17;
      4'b0011: s = 5'd22;
      4'b0100: s = 5'd5;
      4'b0101: s = 5'd9;
      4'b0110: s = 5'd14;
      4'b0111: s = 5'd20;
      4'b1000: s = 5'd4;
      4'b1001: s = 5'd11;
      4'b1010: s = 5'd16;
      4'b1011: s = 5'd23;
      4'b1100: s = 5'd6;
      4'b1101: s = 5'd10;
      4'b1110: s = 5'd15;
      4'b1111: s = 5'd21;
      default: s = 5'd0;
    endcase
    return s;
  endfunction

  // 4-bit arithmetic wraps mod 16, which is exactly the MD5 message index rule.
  function automatic logic [3:0] msgIndex(input logic [5:0] idx);
    logic [3:0] i4;
    logic [3:0] g;
    i4 = idx[3:0];
    case (idx[5:4])
      2'd0:    g = i4;
      2'd1:    g = i4 * 4'd5 + 4'd1;
      2'd2:    g = i4 * 4'd3 + 4'd5;
      default: g = i4 * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (5'd0 - s));
  endfunction

  function automatic logic [127:0] md5Round(input logic [5:0] idx,
                                            input logic [127:0] state,
                                            input logic [511:0] block);
    logic [31:0] a, b, c, d, f, m, sum, newB;
    logic [3:0]  g;
    a = state[127:96];
    b = state[95:64];
    c = state[63:32];
    d = state[31:0];
    case (idx[5:4])
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    g    = msgIndex(idx);
    m    = block[{g, 5'b0} +: 32];
    sum  = a + f + roundK(idx) + m;
    newB = b + rotl(sum, roundShift(idx));
    return {d, newB, b, c};
  endfunction

  logic         r_valid [64];
  logic [127:0] r_state [64];
  logic [511:0] r_block [64];
  logic [127:0] r_init  [64];
  logic [127:0] w_next  [64];

  // Stage 0 applies round 0 directly to the incoming chunk; stage n applies round n.
  always_comb begin
    w_next[0] = md5Round(6'd0, init_val_i, wb_i);
    for (int n = 1; n < 64; n++) begin
      w_next[n] = md5Round(6'(n), r_state[n-1], r_block[n-1]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int n = 0; n < 64; n++) begin
        r_valid[n] <= 1'b0;
        r_state[n] <= '0;
        r_block[n] <= '0;
        r_init[n]  <= '0;
      end
    end else if (en_i) begin
      r_valid[0] <= valid_i;
      r_state[0] <= w_next[0];
      r_block[0] <= wb_i;
      r_init[0]  <= init_val_i;
      for (int n = 1; n < 64; n++) begin
        r_valid[n] <= r_valid[n-1];
        r_state[n] <= w_next[n];
        r_block[n] <= r_block[n-1];
        r_init[n]  <= r_init[n-1];
      end
    end
  end

  logic [127:0] w_final;
  logic [127:0] w_init;

  assign w_final     = r_state[63];
  assign w_init      = r_init[63];
  assign valid_o     = r_valid[63];
  assign footprint_o = {w_final[127:96] + w_init[127:96],
                        w_final[95:64]  + w_init[95:64],
                        w_final[63:32]  + w_init[63:32],
                        w_final[31:0]   + w_init[31:0]};

endmodule

// File: tb/tb_md5_core.sv
// Directed bench for md5_core: known MD5 digests, exact latency, stall, mid-flight reset and idle checks.
module tb_md5_core;

  logic         clk_i;
  logic         rst_i;
  logic         en_i;
  logic         valid_i;
  logic [511:0] wb_i;
  logic [127:0] init_val_i;
  logic         valid_o;
  logic [127:0] footprint_o;

  md5_core dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .valid_i     (valid_i),
    .wb_i        (wb_i),
    .init_val_i  (init_val_i),
    .valid_o     (valid_o),
    .footprint_o (footprint_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string        name;
    logic [511:0] wb;
    logic [127:0] init;
    logic [127:0] expect_fp;
  } vec_t;

  localparam logic [127:0] STD_INIT = 128'h67452301efcdab8998badcfe10325476;

  vec_t vecs[5];
  int   testsRun;
  int   testsFailed;

  function automatic logic [511:0] mkBlock(input logic [31:0] w0, w1, w2, w3, w4, w5, w6,
                                           input logic [31:0] lenBits);
    logic [511:0] blk;
    blk = '0;
    blk[31:0]    = w0;
    blk[63:32]   = w1;
    blk[95:64]   = w2;
    blk[127:96]  = w3;
    blk[159:128] = w4;
    blk[191:160] = w5;
    blk[223:192] = w6;
    blk[479:448] = lenBits;
    return blk;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [511:0] wb, input logic [127:0] init);
    valid_i    = v;
    wb_i       = wb;
    init_val_i = init;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int  got;
    int  edges;
    bit  sawEarly;
    bit  seen;
    bit  sawValid;

    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{"empty", mkBlock(32'h00000080, 0, 0, 0, 0, 0, 0, 32'h0), STD_INIT,
                128'hd98c1dd404b2008f980980e97e42f8ec};
    vecs[1] = '{"abc", mkBlock(32'h80636261, 0, 0, 0, 0, 0, 0, 32'h18), STD_INIT,
                128'h98500190b04fd23c7d3f96d6727fe128};
    vecs[2] = '{"a", mkBlock(32'h00008061, 0, 0, 0, 0, 0, 0, 32'h8), STD_INIT,
                128'hb975c10ca8b6f1c0e299c33161267769};
    vecs[3] = '{"msgDigest", mkBlock(32'h7373656d, 32'h20656761, 32'h65676964, 32'h00807473,
                0, 0, 0, 32'h70), STD_INIT,
                128'h7d696bf98d93b77c312f5a52d061f1aa};
    vecs[4] = '{"alphabet", mkBlock(32'h64636261, 32'h68676665, 32'h6c6b6a69, 32'h706f6e6d,
                32'h74737271, 32'h78777675, 32'h00807a79, 32'hd0), STD_INIT,
                128'hd7d3fcc300e492616c49fb7d3be167ca};

    rst_i = 1'b0;
    en_i  = 1'b0;
    applyStimulus(1'b0, '0, '0);
    repeat (3) step();
    checkOutput("resetValid", 128'(valid_o), 128'd0);
    checkOutput("resetFootprint", footprint_o, 128'd0);

    rst_i = 1'b1;
    en_i  = 1'b1;

    // Single chunk: captured on edge 1, result visible after edge 64, one-cycle pulse.
    applyStimulus(1'b1, vecs[0].wb, vecs[0].init);
    step();
    applyStimulus(1'b0, '0, '0);
    sawEarly = 1'b0;
    for (int e = 2; e <= 63; e++) begin
      step();
      if (valid_o) sawEarly = 1'b1;
    end
    checkOutput("earlyValid", 128'(sawEarly), 128'd0);
    step();
    checkOutput("latencyValid", 128'(valid_o), 128'd1);
    checkOutput("latencyDigest", footprint_o, vecs[0].expect_fp);
    step();
    checkOutput("pulseEnd", 128'(valid_o), 128'd0);

    // Table of vectors issued back-to-back; results must arrive on consecutive edges in order.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, vecs[v].wb, vecs[v].init);
      step();
    end
    applyStimulus(1'b0, '0, '0);
    got = 0;
    for (int e = 6; e <= 200 && got < 5; e++) begin
      step();
      if (valid_o) begin
        checkOutput({"digest_", vecs[got].name}, footprint_o, vecs[got].expect_fp);
        checkOutput({"arrival_", vecs[got].name}, 128'(e), 128'(got + 64));
        got++;
      end
    end
    checkOutput("tableCount", 128'(got), 128'd5);
    step();
    checkOutput("tableTail", 128'(valid_o), 128'd0);

    // Five-cycle stall mid-flight with junk on the inputs that must be ignored.
    applyStimulus(1'b1, vecs[1].wb, vecs[1].init);
    step();
    edges = 1;
    applyStimulus(1'b0, '0, '0);
    repeat (29) begin
      step();
      edges++;
    end
    en_i = 1'b0;
    applyStimulus(1'b1, vecs[0].wb, vecs[0].init);
    repeat (5) begin
      step();
      edges++;
    end
    en_i = 1'b1;
    applyStimulus(1'b0, '0, '0);
    seen = 1'b0;
    while (!seen && edges < 200) begin
      step();
      edges++;
      if (valid_o) seen = 1'b1;
    end
    checkOutput("stallArrival", 128'(edges), 128'd69);
    checkOutput("stallDigest", footprint_o, vecs[1].expect_fp);
    step();
    checkOutput("stallPulseEnd", 128'(valid_o), 128'd0);
    sawValid = 1'b0;
    repeat (80) begin
      step();
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("stallInputIgnored", 128'(sawValid), 128'd0);

    // Reset while the first of three chunks is at the output and two more are in flight.
    for (int v = 0; v < 3; v++) begin
      applyStimulus(1'b1, vecs[v].wb, vecs[v].init);
      step();
    end
    applyStimulus(1'b0, '0, '0);
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 200) begin
      step();
      edges++;
      if (valid_o) seen = 1'b1;
    end
    checkOutput("preResetValid", 128'(valid_o), 128'd1);
    checkOutput("preResetDigest", footprint_o, vecs[0].expect_fp);
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("asyncResetValid", 128'(valid_o), 128'd0);
    checkOutput("asyncResetFootprint", footprint_o, 128'd0);
    step();
    step();
    rst_i = 1'b1;
    sawValid = 1'b0;
    repeat (100) begin
      step();
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("idleAfterReset", 128'(sawValid), 128'd0);

    applyStimulus(1'b1, vecs[3].wb, vecs[3].init);
    step();
    edges = 1;
    applyStimulus(1'b0, '0, '0);
    seen = 1'b0;
    while (!seen && edges < 200) begin
      step();
      edges++;
      if (valid_o) seen = 1'b1;
    end
    checkOutput("postResetArrival", 128'(edges), 128'd64);
    checkOutput("postResetDigest", footprint_o, vecs[3].expect_fp);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/md5_core.md
MD5_CORE -- requirements
Module: md5_core

Interface
REQ-001 SHALL: clk_i, input, 1 bit; single clock, all state updates on rising edge.
REQ-002 SHALL: rst_i, input, 1 bit; asynchronous, active-low reset.
REQ-003 SHALL: en_i, input, 1 bit; pipeline advance enable (1 = advance, 0 = hold all state).
REQ-004 SHALL: valid_i, input, 1 bit; wb_i/init_val_i carry a chunk this cycle.
REQ-005 SHALL: wb_i, input, 512 bits; message block, word M[i] = wb_i[32*i+31:32*i], i = 0..15, each word already in MD5 little-endian word form.
REQ-006 SHALL: init_val_i, input, 128 bits; chaining value {A,B,C,D}, A at [127:96], D at [31:0].
REQ-007 SHALL: valid_o, output, 1 bit; footprint_o holds a finished result.
REQ-008 SHALL: footprint_o, output, 128 bits; {A+a0, B+b0, C+c0, D+d0}, same word order as init_val_i, no byte swapping.

Function
REQ-009 SHALL: one MD5 compression (RFC 1321, 64 rounds, standard K[] and shift tables, F/G/H/I round functions, message index per round) per accepted chunk; no padding logic (caller supplies padded blocks).
REQ-010 SHALL: fully pipelined, 64 register stages, stage n performs round n-1; throughput one chunk per enabled cycle.
REQ-011 SHALL: each stage carries valid bit, working a/b/c/d, the full 512-bit block, and the initial chaining value (needed for final add), so chunks with different init_val_i may be interleaved.
REQ-012 SHALL: chunk sampled on rising edge with en_i=1; valid_o and footprint_o for it appear exactly 64 enabled rising edges later (final 32-bit modular additions combinational off the last stage register).
REQ-013 SHALL: en_i=0 freezes every stage register; valid_i/wb_i ignored; outputs stable.
REQ-014 SHALL: a stage with valid=0 still propagates (bubble); valid_o=0 for bubbles, footprint_o value don't-care but deterministic.
REQ-015 SHALL: all additions modulo 2^32; rotations left by the per-round constant.
REQ-016 SHALL: back-to-back valid_i produce back-to-back valid_o in the same order; no back-pressure, no overflow condition.

Reset
REQ-017 SHALL: rst_i=0 asynchronously clears all stage valid bits and all data registers to 0; valid_o=0, footprint_o = combinational sum of zeros (0) while held.
REQ-018 SHALL: reset mid-operation discards all in-flight chunks; first chunk after release returns 64 enabled edges after its capture.
REQ-019 SHALL: after release, first input sampled on the next rising edge with en_i=1.

Verification
REQ-020 SHALL: empty message, M0=0x00000080, others 0, init 0x67452301efcdab8998badcfe10325476 -> after 64 edges valid_o=1, footprint_o=0xd98c1dd404b2008f980980e97e42f8ec.
REQ-021 SHALL: "abc", M0=0x80636261, M14=0x00000018, others 0, same init -> footprint_o=0x98500190b04fd23c7d3f96d6727fe128.
REQ-022 SHALL: both vectors on consecutive cycles -> valid_o high on two consecutive cycles, results in order, no corruption.
REQ-023 SHALL: en_i dropped for 5 cycles mid-flight -> result arrives 5 cycles later, value unchanged, valid_o pulse width unchanged.
REQ-024 SHALL: rst_i asserted with 3 chunks in flight -> valid_o=0 immediately and stays 0 until a new chunk completes.
REQ-025 SHALL: valid_i=0 continuously -> valid_o never asserts.
